axi_rq_arbiter: RTL and testbench

- Packet-granular round-robin arbiter sharing one PCIe requester-request (RQ) AXI4-Stream port between REQUESTERS independent DMA/requester engines.
- Sits between the requester engines and the PCIe hard-IP RQ interface.
- A packet is never interleaved. Ownership is held from the first beat to the beat where TLAST is accepted.
- Adds no arbitration bubble between back-to-back packets and provides per-requester enable and packet counters for the driver/debug path.

---
 rtl/axi_rq_arbiter.sv | 148 ++++++++++++++
 tb/tb_axi_rq_arbiter.sv | 578 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rq_arbiter.sv
// Packet-granular round-robin arbiter that shares one PCIe requester-request
// AXI4-Stream port between several requester engines with zero-latency switching.
module axi_rq_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 137,
    parameter int KEEP_WIDTH = DATA_WIDTH / 32,
    parameter int CNT_WIDTH  = 32,
    localparam int IDX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                             CLK,
    input  logic                             RESET,

    input  logic [REQUESTERS*DATA_WIDTH-1:0] RQ_IN_DATA,
    input  logic [REQUESTERS*USER_WIDTH-1:0] RQ_IN_USER,
    input  logic [REQUESTERS*KEEP_WIDTH-1:0] RQ_IN_KEEP,
    input  logic [REQUESTERS-1:0]            RQ_IN_LAST,
    input  logic [REQUESTERS-1:0]            RQ_IN_VALID,
    output logic [REQUESTERS-1:0]            RQ_IN_READY,

    output logic [DATA_WIDTH-1:0]            RQ_OUT_DATA,
    output logic [USER_WIDTH-1:0]            RQ_OUT_USER,
    output logic [KEEP_WIDTH-1:0]            RQ_OUT_KEEP,
    output logic                             RQ_OUT_LAST,
    output logic                             RQ_OUT_VALID,
    input  logic                             RQ_OUT_READY,

    input  logic [REQUESTERS-1:0]            CFG_ENABLE,
    output logic [REQUESTERS*CNT_WIDTH-1:0]  STAT_PKT_CNT,
    output logic [IDX_WIDTH-1:0]             STAT_OWNER
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;
    logic [IDX_WIDTH-1:0] rr_q, rr_d;
    logic [IDX_WIDTH-1:0] last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q [REQUESTERS];
    logic [CNT_WIDTH-1:0] cnt_d [REQUESTERS];

    logic [DATA_WIDTH-1:0] inData [REQUESTERS];
    logic [USER_WIDTH-1:0] inUser [REQUESTERS];
    logic [KEEP_WIDTH-1:0] inKeep [REQUESTERS];

    logic [REQUESTERS-1:0] cand;
    logic                  found;
    logic [IDX_WIDTH-1:0]  rrSel;
    logic [IDX_WIDTH-1:0]  sel;
    logic [IDX_WIDTH-1:0]  selNext;
    logic                  active;
    logic                  accept;

    for (genvar g = 0; g < REQUESTERS; g++) begin : g_slice
        assign inData[g] = RQ_IN_DATA[g*DATA_WIDTH +: DATA_WIDTH];
        assign inUser[g] = RQ_IN_USER[g*USER_WIDTH +: USER_WIDTH];
        assign inKeep[g] = RQ_IN_KEEP[g*KEEP_WIDTH +: KEEP_WIDTH];
        assign STAT_PKT_CNT[g*CNT_WIDTH +: CNT_WIDTH] = RESET ? '0 : cnt_q[g];
    end

    assign cand = RQ_IN_VALID & CFG_ENABLE;

    // Rotating priority search: first enabled, valid requester at or after rr.
    always_comb begin
        int                   idx;
        logic [IDX_WIDTH-1:0] idxN;
        found = 1'b0;
        rrSel = rr_q;
        idx   = 0;
        idxN  = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            idxN = IDX_WIDTH'(idx);
            if (!found && cand[idxN]) begin
                found = 1'b1;
                rrSel = idxN;
            end
        end
    end

    assign sel     = (state_q == BUSY) ? owner_q : rrSel;
    assign active  = (state_q == BUSY) || found;
    assign selNext = (sel == IDX_WIDTH'(REQUESTERS - 1)) ? '0 : sel + IDX_WIDTH'(1);

    always_comb begin
        RQ_OUT_DATA  = inData[sel];
        RQ_OUT_USER  = inUser[sel];
        RQ_OUT_KEEP  = inKeep[sel];
        RQ_OUT_LAST  = RQ_IN_LAST[sel];
        RQ_OUT_VALID = !RESET && active && RQ_IN_VALID[sel];
        RQ_IN_READY  = '0;
        if (!RESET && active) begin
            RQ_IN_READY[sel] = RQ_OUT_READY;
        end
    end

    assign accept     = RQ_OUT_VALID && RQ_OUT_READY;
    assign STAT_OWNER = RESET ? '0 : (active ? sel : last_q);

    // Ownership locks on a non-final beat and is released on the accepted TLAST.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        last_d  = last_q;
        for (int r = 0; r < REQUESTERS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (accept) begin
            last_d = sel;
            if (RQ_OUT_LAST) begin
                state_d    = IDLE;
                rr_d       = selNext;
                cnt_d[sel] = cnt_q[sel] + CNT_WIDTH'(1);
            end else begin
                state_d = BUSY;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            last_q  <= '0;
            for (int r = 0; r < REQUESTERS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            for (int r = 0; r < REQUESTERS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_axi_rq_arbiter.sv
// Scoreboard bench for axi_rq_arbiter: requester sources are beat queues, and
// the expected output stream is queued in grant order and popped on acceptance.
module tb_axi_rq_arbiter;

    localparam int R  = 4;
    localparam int DW = 512;
    localparam int UW = 137;
    localparam int KW = DW / 32;
    localparam int CW = 4;

    typedef struct {
        logic [1:0]    r;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic            clk;
    logic            reset;
    logic [R*DW-1:0] inData;
    logic [R*UW-1:0] inUser;
    logic [R*KW-1:0] inKeep;
    logic [R-1:0]    inLast;
    logic [R-1:0]    inValid;
    logic [R-1:0]    inReady;
    logic [DW-1:0]   outData;
    logic [UW-1:0]   outUser;
    logic [KW-1:0]   outKeep;
    logic            outLast;
    logic            outValid;
    logic            outReady;
    logic [R-1:0]    cfgEnable;
    logic [R*CW-1:0] statCnt;
    logic [1:0]      statOwner;

    beat_t srcQ [R][$];
    beat_t expQ [$];
    int    compared;
    int    mismatched;

    axi_rq_arbiter #(
        .REQUESTERS (R),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .KEEP_WIDTH (KW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK          (clk),
        .RESET        (reset),
        .RQ_IN_DATA   (inData),
        .RQ_IN_USER   (inUser),
        .RQ_IN_KEEP   (inKeep),
        .RQ_IN_LAST   (inLast),
        .RQ_IN_VALID  (inValid),
        .RQ_IN_READY  (inReady),
        .RQ_OUT_DATA  (outData),
        .RQ_OUT_USER  (outUser),
        .RQ_OUT_KEEP  (outKeep),
        .RQ_OUT_LAST  (outLast),
        .RQ_OUT_VALID (outValid),
        .RQ_OUT_READY (outReady),
        .CFG_ENABLE   (cfgEnable),
        .STAT_PKT_CNT (statCnt),
        .STAT_OWNER   (statOwner)
    );

    always #5 clk = ~clk;

    function automatic beat_t mkBeat(input int r, input int pkt, input int b, input bit last);
        beat_t       x;
        logic [31:0] w;
        w      = {8'hD0 | 8'(r), 8'(pkt), 8'(b), 8'h5A};
        x.r    = 2'(r);
        x.data = {16{w}};
        x.user = {105'(0), w ^ 32'h1357_9BDF};
        x.keep = last ? 16'h00FF : 16'hFFFF;
        x.last = last;
        return x;
    endfunction

    task automatic loadPkt(input int r, input int pkt, input int n);
        for (int b = 0; b < n; b++) begin
            srcQ[r].push_back(mkBeat(r, pkt, b, b == n - 1));
        end
    endtask

    task automatic expPkt(input int r, input int pkt, input int n);
        for (int b = 0; b < n; b++) begin
            expQ.push_back(mkBeat(r, pkt, b, b == n - 1));
        end
    endtask

    task automatic driveInputs();
        for (int r = 0; r < R; r++) begin
            if (srcQ[r].size() > 0) begin
                inValid[r]            = 1'b1;
                inLast[r]             = srcQ[r][0].last;
                inData[r*DW +: DW]    = srcQ[r][0].data;
                inUser[r*UW +: UW]    = srcQ[r][0].user;
                inKeep[r*KW +: KW]    = srcQ[r][0].keep;
            end else begin
                inValid[r]            = 1'b0;
                inLast[r]             = 1'b0;
                inData[r*DW +: DW]    = '0;
                inUser[r*UW +: UW]    = '0;
                inKeep[r*KW +: KW]    = '0;
            end
        end
    endtask

    task automatic advance();
        logic [R-1:0] acc;
        beat_t        dropped;
        acc = inValid & inReady;
        @(posedge clk);
        for (int r = 0; r < R; r++) begin
            if (acc[r] && srcQ[r].size() > 0) begin
                dropped = srcQ[r].pop_front();
            end
        end
        #1;
        driveInputs();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        for (int r = 0; r < R; r++) begin
            srcQ[r].delete();
        end
        expQ.delete();
        driveInputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        driveInputs();
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cfgEnable = '1;
        outReady  = 1'b1;
        loadPkt(0, 0, 2);
        driveInputs();
        @(posedge clk);
        #2;
        compared++;
        if (outValid !== 1'b0 || inReady !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got valid=%b ready=%b, want valid=0 ready=0000", outValid, inReady);
        end
        compared++;
        if (statCnt !== '0 || statOwner !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold_stat: got cnt=%h owner=%0d, want 0/0", statCnt, statOwner);
        end
        doReset();
        compared++;
        if (outValid !== 1'b0 || inReady !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: got valid=%b ready=%b, want valid=0 ready=0000", outValid, inReady);
        end
        compared++;
        if (statCnt !== '0 || statOwner !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle_stat: got cnt=%h owner=%0d, want 0/0", statCnt, statOwner);
        end
    endtask

    task automatic test_single();
        beat_t e;
        int    bubbles;
        doReset();
        cfgEnable = '1;
        outReady  = 1'b1;
        loadPkt(0, 1, 3);
        expPkt(0, 1, 3);
        driveInputs();
        #1;
        bubbles = 0;
        for (int c = 0; c < 20 && expQ.size() > 0; c++) begin
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || outUser !== e.user || outKeep !== e.keep ||
                    outLast !== e.last || inReady !== (4'b0001 << e.r) || statOwner !== e.r) begin
                    mismatched++;
                    $display("[TB] FAIL single_beat: got data=%h last=%b ready=%b owner=%0d, want data=%h last=%b ready=%b owner=%0d",
                             outData[31:0], outLast, inReady, statOwner, e.data[31:0], e.last, 4'b0001 << e.r, e.r);
                end
            end else begin
                bubbles++;
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0 || bubbles != 0) begin
            mismatched++;
            $display("[TB] FAIL single_timing: got left=%0d bubbles=%0d, want 0/0", expQ.size(), bubbles);
        end
        compared++;
        if (statCnt !== 16'h0001) begin
            mismatched++;
            $display("[TB] FAIL single_cnt: got %h, want 0001", statCnt);
        end
        // rr now points at requester 1, so it wins over requester 0.
        loadPkt(0, 2, 1);
        loadPkt(1, 2, 1);
        expPkt(1, 2, 1);
        expPkt(0, 2, 1);
        driveInputs();
        #1;
        for (int c = 0; c < 20 && expQ.size() > 0; c++) begin
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || inReady !== (4'b0001 << e.r) || statOwner !== e.r) begin
                    mismatched++;
                    $display("[TB] FAIL single_rr: got data=%h ready=%b owner=%0d, want data=%h ready=%b owner=%0d",
                             outData[31:0], inReady, statOwner, e.data[31:0], 4'b0001 << e.r, e.r);
                end
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL single_rr_timeout: got %0d beats left, want 0", expQ.size());
        end
    endtask

    task automatic test_round_robin();
        beat_t e;
        int    bubbles;
        doReset();
        cfgEnable = '1;
        outReady  = 1'b1;
        loadPkt(0, 10, 2);
        loadPkt(0, 11, 2);
        loadPkt(1, 12, 2);
        loadPkt(2, 13, 2);
        loadPkt(3, 14, 2);
        expPkt(0, 10, 2);
        expPkt(1, 12, 2);
        expPkt(2, 13, 2);
        expPkt(3, 14, 2);
        expPkt(0, 11, 2);
        driveInputs();
        #1;
        bubbles = 0;
        for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || outLast !== e.last || inReady !== (4'b0001 << e.r) || statOwner !== e.r) begin
                    mismatched++;
                    $display("[TB] FAIL rr_beat: got data=%h last=%b ready=%b owner=%0d, want data=%h last=%b ready=%b owner=%0d",
                             outData[31:0], outLast, inReady, statOwner, e.data[31:0], e.last, 4'b0001 << e.r, e.r);
                end
            end else begin
                bubbles++;
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0 || bubbles != 0) begin
            mismatched++;
            $display("[TB] FAIL rr_bubbles: got left=%0d bubbles=%0d, want 0/0", expQ.size(), bubbles);
        end
        compared++;
        if (statCnt !== 16'h1112) begin
            mismatched++;
            $display("[TB] FAIL rr_cnt: got %h, want 1112", statCnt);
        end
    endtask

    task automatic test_no_interleave();
        beat_t e;
        doReset();
        cfgEnable = '1;
        outReady  = 1'b1;
        loadPkt(1, 20, 4);
        expPkt(1, 20, 4);
        driveInputs();
        #1;
        for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
            if (c == 1) begin
                loadPkt(0, 21, 2);
                loadPkt(2, 22, 2);
                expPkt(2, 22, 2);
                expPkt(0, 21, 2);
                driveInputs();
                #1;
            end
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || outLast !== e.last || inReady !== (4'b0001 << e.r) || statOwner !== e.r) begin
                    mismatched++;
                    $display("[TB] FAIL lock_beat: got data=%h last=%b ready=%b owner=%0d, want data=%h last=%b ready=%b owner=%0d",
                             outData[31:0], outLast, inReady, statOwner, e.data[31:0], e.last, 4'b0001 << e.r, e.r);
                end
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0 || statCnt !== 16'h0111) begin
            mismatched++;
            $display("[TB] FAIL lock_end: got left=%0d cnt=%h, want 0/0111", expQ.size(), statCnt);
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        int    doneCycle;
        doReset();
        cfgEnable = '1;
        loadPkt(0, 30, 3);
        loadPkt(1, 31, 1);
        expPkt(0, 30, 3);
        expPkt(1, 31, 1);
        driveInputs();
        doneCycle = -1;
        for (int c = 0; c < 30 && expQ.size() > 0; c++) begin
            outReady = 1'(c % 2);
            #1;
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || outLast !== e.last || inReady !== (4'b0001 << e.r)) begin
                    mismatched++;
                    $display("[TB] FAIL bp_beat: got data=%h last=%b ready=%b, want data=%h last=%b ready=%b",
                             outData[31:0], outLast, inReady, e.data[31:0], e.last, 4'b0001 << e.r);
                end
                if (e.r == 2'd0 && e.last) begin
                    doneCycle = c;
                end
            end else if (!outReady) begin
                compared++;
                if (outValid !== 1'b1 || outData !== expQ[0].data || inReady !== 4'b0000) begin
                    mismatched++;
                    $display("[TB] FAIL bp_stall: got valid=%b data=%h ready=%b, want valid=1 data=%h ready=0000",
                             outValid, outData[31:0], inReady, expQ[0].data[31:0]);
                end
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0 || doneCycle != 5) begin
            mismatched++;
            $display("[TB] FAIL bp_done: got left=%0d last_cycle=%0d, want 0/5", expQ.size(), doneCycle);
        end
        outReady = 1'b1;
    endtask

    task automatic test_enable();
        beat_t e;
        doReset();
        cfgEnable = 4'b1011;
        outReady  = 1'b1;
        loadPkt(0, 40, 2);
        loadPkt(1, 40, 2);
        loadPkt(2, 40, 2);
        loadPkt(3, 40, 2);
        expPkt(0, 40, 2);
        expPkt(1, 40, 2);
        expPkt(3, 40, 2);
        driveInputs();
        #1;
        for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || inReady !== (4'b0001 << e.r)) begin
                    mismatched++;
                    $display("[TB] FAIL en_beat: got data=%h ready=%b, want data=%h ready=%b",
                             outData[31:0], inReady, e.data[31:0], 4'b0001 << e.r);
                end
            end
            advance();
        end
        repeat (3) begin
            compared++;
            if (inReady[2] !== 1'b0 || outValid !== 1'b0 || expQ.size() != 0) begin
                mismatched++;
                $display("[TB] FAIL en_masked: got valid=%b ready=%b left=%0d, want valid=0 ready=0000 left=0",
                         outValid, inReady, expQ.size());
            end
            advance();
        end
        // Dropping the owner's enable mid-packet must not cut the packet short.
        loadPkt(0, 41, 3);
        expPkt(0, 41, 3);
        driveInputs();
        #1;
        for (int c = 0; c < 20 && expQ.size() > 0; c++) begin
            if (c == 1) begin
                cfgEnable = 4'b1010;
                #1;
            end
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || outLast !== e.last || inReady !== (4'b0001 << e.r)) begin
                    mismatched++;
                    $display("[TB] FAIL en_clear_beat: got data=%h last=%b ready=%b, want data=%h last=%b ready=%b",
                             outData[31:0], outLast, inReady, e.data[31:0], e.last, 4'b0001 << e.r);
                end
            end else begin
                compared++;
                mismatched++;
                $display("[TB] FAIL en_clear_gap: got valid=%b ready=%b, want valid=1 mid-packet", outValid, inReady);
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0 || outValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL en_clear_end: got left=%0d valid=%b, want 0/0", expQ.size(), outValid);
        end
        cfgEnable = 4'b1111;
        expPkt(2, 40, 2);
        #1;
        for (int c = 0; c < 20 && expQ.size() > 0; c++) begin
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || inReady !== (4'b0001 << e.r)) begin
                    mismatched++;
                    $display("[TB] FAIL en_restore_beat: got data=%h ready=%b, want data=%h ready=%b",
                             outData[31:0], inReady, e.data[31:0], 4'b0001 << e.r);
                end
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0 || statCnt !== 16'h1112) begin
            mismatched++;
            $display("[TB] FAIL en_cnt: got left=%0d cnt=%h, want 0/1112", expQ.size(), statCnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t e;
        doReset();
        cfgEnable = '1;
        outReady  = 1'b1;
        loadPkt(1, 50, 1);
        driveInputs();
        #1;
        advance();
        loadPkt(2, 51, 4);
        driveInputs();
        #1;
        advance();
        compared++;
        if (outValid !== 1'b1 || inReady !== 4'b0100 || statCnt !== 16'h0010) begin
            mismatched++;
            $display("[TB] FAIL rst_pre: got valid=%b ready=%b cnt=%h, want 1/0100/0010", outValid, inReady, statCnt);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (outValid !== 1'b0 || inReady !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL rst_same_cycle: got valid=%b ready=%b, want 0/0000", outValid, inReady);
        end
        compared++;
        if (statCnt !== '0 || statOwner !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL rst_same_cycle_stat: got cnt=%h owner=%0d, want 0/0", statCnt, statOwner);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < R; r++) begin
            srcQ[r].delete();
        end
        reset = 1'b0;
        driveInputs();
        #1;
        compared++;
        if (statCnt !== '0 || statOwner !== 2'd0 || outValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_release: got cnt=%h owner=%0d valid=%b, want 0/0/0", statCnt, statOwner, outValid);
        end
        loadPkt(3, 52, 1);
        loadPkt(1, 53, 1);
        expPkt(1, 53, 1);
        expPkt(3, 52, 1);
        driveInputs();
        #1;
        for (int c = 0; c < 20 && expQ.size() > 0; c++) begin
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || inReady !== (4'b0001 << e.r) || statOwner !== e.r) begin
                    mismatched++;
                    $display("[TB] FAIL rst_regrant: got data=%h ready=%b owner=%0d, want data=%h ready=%b owner=%0d",
                             outData[31:0], inReady, statOwner, e.data[31:0], 4'b0001 << e.r, e.r);
                end
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL rst_regrant_timeout: got %0d beats left, want 0", expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        int    bubbles;
        doReset();
        cfgEnable = '1;
        outReady  = 1'b1;
        for (int p = 0; p < 17; p++) begin
            loadPkt(3, 60 + p, 1);
            expPkt(3, 60 + p, 1);
        end
        driveInputs();
        #1;
        bubbles = 0;
        for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
            if (outValid && outReady) begin
                e = expQ.pop_front();
                compared++;
                if (outData !== e.data || outLast !== 1'b1 || inReady !== 4'b1000) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_beat: got data=%h last=%b ready=%b, want data=%h last=1 ready=1000",
                             outData[31:0], outLast, inReady, e.data[31:0]);
                end
            end else begin
                bubbles++;
            end
            advance();
        end
        compared++;
        if (expQ.size() != 0 || bubbles != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_bubbles: got left=%0d bubbles=%0d, want 0/0", expQ.size(), bubbles);
        end
        compared++;
        if (statCnt !== 16'h1000) begin
            mismatched++;
            $display("[TB] FAIL b2b_wrap: got cnt=%h, want 1000", statCnt);
        end
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        inData     = '0;
        inUser     = '0;
        inKeep     = '0;
        inLast     = '0;
        inValid    = '0;
        outReady   = 1'b0;
        cfgEnable  = '0;
        compared   = 0;
        mismatched = 0;

        test_reset();
        test_single();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_enable();
        test_reset_mid_packet();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
